local_network_interface: RTL

LOCAL_NETWORK_INTERFACE -- requirements
Module: local_network_interface

---
 rtl/local_network_interface.sv | 137 +++++++++++++
 1 files changed

// File: rtl/local_network_interface.sv
// Local network interface: core TX request -> registered flit toward the router,
// router ejection -> 4-entry FWFT RX queue. Optional macro NI_RX_DROP_CNT_EN enables the drop counter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module local_network_interface #(
    parameter logic [2:0] ROUTER_ADDRESS = 3'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tx_req,
    input  logic [2:0]             tx_dst,
    input  logic [25:0]            tx_payload,
    output logic                   tx_ready,
    output logic [`DATA_WIDTH-1:0] NI_DATA_OUT,
    output logic                   NI_DATA_VALID_OUT,
    input  logic                   NI_FULL_IN,
    input  logic [31:0]            NI_DATA_IN,
    input  logic                   NI_DATA_VALID_IN,
    output logic                   rx_valid,
    output logic [31:0]            rx_data,
    input  logic                   rx_ready,
    output logic                   rx_misroute,
    output logic [7:0]             rx_drop_cnt
);
    typedef enum logic {IDLE, SEND} tx_state_e;

    tx_state_e               tx_state_q, tx_state_d;
    logic [31:0]             tx_flit_q, tx_flit_d;
    logic                    out_vld_q, out_vld_d;
    logic [`DATA_WIDTH-1:0]  out_data_q, out_data_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_flit_d  = tx_flit_q;
        out_vld_d  = 1'b0;
        out_data_d = '0;
        case (tx_state_q)
            IDLE: if (tx_req) begin
                tx_flit_d  = {tx_payload, ROUTER_ADDRESS, tx_dst};
                tx_state_d = SEND;
            end
            SEND: if (!NI_FULL_IN) begin
                out_vld_d  = 1'b1;
                out_data_d = tx_flit_q;
                tx_state_d = IDLE;
            end
            default: tx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            tx_flit_q  <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_flit_q  <= tx_flit_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    assign tx_ready          = (tx_state_q == IDLE);
    assign NI_DATA_VALID_OUT = out_vld_q;
    assign NI_DATA_OUT       = out_data_q;

    logic [31:0] mem_q [4];
    logic [31:0] mem_d [4];
    logic [1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        mis_q, mis_d;
    logic        push, pop;

    // Push admission looks only at the pre-edge count, so a full queue drops even during a pop.
    assign pop  = (cnt_q != 3'd0) && rx_ready;
    assign push = NI_DATA_VALID_IN && (cnt_q != 3'd4);

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        mis_d  = mis_q | (NI_DATA_VALID_IN && (NI_DATA_IN[2:0] != ROUTER_ADDRESS));
        if (push) begin
            mem_d[wptr_q] = NI_DATA_IN;
            wptr_d        = wptr_q + 2'd1;
        end
        if (pop) rptr_d = rptr_q + 2'd1;
        if (push && !pop)      cnt_d = cnt_q + 3'd1;
        else if (pop && !push) cnt_d = cnt_q - 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            mis_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            mis_q  <= mis_d;
        end
    end

    assign rx_valid    = (cnt_q != 3'd0);
    assign rx_data     = rx_valid ? mem_q[rptr_q] : 32'd0;
    assign rx_misroute = mis_q;

`ifdef NI_RX_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       drop;

    assign drop = NI_DATA_VALID_IN && (cnt_q == 3'd4);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign rx_drop_cnt = drop_cnt_q;
`else
    assign rx_drop_cnt = 8'd0;
`endif
endmodule
